mem_intf_arbiter: RTL and testbench

- Shares the single simple-memory interface of the AXI4-lite adapter between two requesters: port 0 is instruction fetch, port 1 is the load/store unit.
- Round-robin arbitration. The winning request is captured into registers, and the downstream request is held stable until it is accepted.
- Inserts a mandatory idle cycle between downstream transactions so the adapter's per-channel handshake flags can clear.
- Provides a watchdog on stalled transactions.

---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/rr_arb2.sv | 13 +
 rtl/mem_intf_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_intf_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory-interface arbiter: FSM states,
// requester ids and the captured request word.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    NULL  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_LSU    = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
    logic        ren;
  } mem_req_t;

  // A request carrying any write strobe is a write; its read enable is dropped.
  function automatic mem_req_t normalise_req(input mem_req_t r);
    mem_req_t n;
    n     = r;
    n.ren = r.ren & ~(|r.wen);
    return n;
  endfunction

  function automatic logic is_null_req(input mem_req_t r);
    return (r.wen == 4'b0000) && !r.ren;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on contention the port that did not win last
// time is chosen, otherwise the single requester wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_id,
  output logic       gnt_valid
);

  assign gnt_valid = |req;
  assign gnt_id    = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/mem_intf_arbiter.sv
// Shares one simple-memory interface between instruction fetch (port 0) and
// the load/store unit (port 1), with a forced idle gap and a stall watchdog.
module mem_intf_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_val,
  output logic        m0_accept,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wen,
  input  logic        m0_ren,
  output logic [31:0] m0_rdata,
  output logic [31:0] m0_error,
  input  logic        m1_val,
  output logic        m1_accept,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wen,
  input  logic        m1_ren,
  output logic [31:0] m1_rdata,
  output logic [31:0] m1_error,
  output logic        s_val,
  input  logic        s_accept,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wen,
  output logic        s_ren,
  input  logic [31:0] s_rdata,
  input  logic [31:0] s_error,
  output logic        busy,
  output logic        timeout_err,
  output logic [1:0]  state_dbg
);

  // Handshake: a requester holds mN_val (and its request fields) until the
  // single-cycle mN_accept; downstream, s_val and s_* stay constant from the
  // first GRANT cycle through the cycle in which s_accept is seen high.

  localparam int              CNT_W  = (TO_W > 0) ? TO_W : 1;
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam bit              WD_EN  = (TIMEOUT_CYCLES > 0);

  state_t           state, state_next;
  logic             last_grant;
  logic             gnt_id, gnt_valid;
  logic             capture;
  logic             done, from_s;
  mem_req_t         m0_req, m1_req, win_req, req_q;
  logic [CNT_W-1:0] wd_cnt, wd_inc;

  rr_arb2 u_rr_arb2 (
    .req        ({m1_val, m0_val}),
    .last_grant (last_grant),
    .gnt_id     (gnt_id),
    .gnt_valid  (gnt_valid)
  );

  assign m0_req  = {m0_addr, m0_wdata, m0_wen, m0_ren};
  assign m1_req  = {m1_addr, m1_wdata, m1_wen, m1_ren};
  assign win_req = (gnt_id == PORT_LSU) ? m1_req : m0_req;
  assign capture = (state == IDLE) && gnt_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_val      = 1'b0;
    done       = 1'b0;
    from_s     = 1'b0;
    case (state)
      IDLE:  if (gnt_valid) state_next = is_null_req(win_req) ? NULL : GRANT;
      GRANT: begin
        s_val = 1'b1;
        if (s_accept) begin
          done       = 1'b1;
          from_s     = 1'b1;
          state_next = GAP;
        end
      end
      NULL: begin
        done       = 1'b1;
        state_next = GAP;
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    m0_accept = done && (last_grant == PORT_IFETCH);
    m1_accept = done && (last_grant == PORT_LSU);
    // Null completions return zero data, never whatever is on s_rdata.
    m0_rdata  = (m0_accept && from_s) ? s_rdata : 32'h0;
    m0_error  = (m0_accept && from_s) ? s_error : 32'h0;
    m1_rdata  = (m1_accept && from_s) ? s_rdata : 32'h0;
    m1_error  = (m1_accept && from_s) ? s_error : 32'h0;
  end

  // last_grant doubles as the id of the port owning the in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= '0;
      last_grant <= PORT_LSU;
    end else if (capture) begin
      req_q      <= normalise_req(win_req);
      last_grant <= gnt_id;
    end
  end

  assign s_addr    = req_q.addr;
  assign s_wdata   = req_q.wdata;
  assign s_wen     = req_q.wen;
  assign s_ren     = req_q.ren;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Watchdog only flags the stall; the transaction keeps waiting in GRANT.
  assign wd_inc = wd_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (capture && (state_next == GRANT)) begin
      wd_cnt <= '0;
    end else if (WD_EN && (state == GRANT) && !s_accept && (wd_cnt != TO_MAX)) begin
      wd_cnt <= wd_inc;
      if (wd_inc == TO_MAX) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_intf_arbiter.sv
// Directed bench for mem_intf_arbiter: scoreboard queues for downstream
// requests and requester completions, checked by negedge monitors.
module tb_mem_intf_arbiter;
  import mem_arb_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_val, m0_accept, m0_ren;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m0_error;
  logic [3:0]  m0_wen;
  logic        m1_val, m1_accept, m1_ren;
  logic [31:0] m1_addr, m1_wdata, m1_rdata, m1_error;
  logic [3:0]  m1_wen;
  logic        s_val, s_accept, s_ren;
  logic [31:0] s_addr, s_wdata, s_rdata, s_error;
  logic [3:0]  s_wen;
  logic        busy, timeout_err;
  logic [1:0]  state_dbg;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [64:0] exp_q[$];    // {port, rdata, error}
  logic [68:0] s_exp_q[$];  // {addr, wdata, wen, ren}
  logic [68:0] s_cur_exp = '0;
  logic        s_active = 1'b0;
  logic [64:0] acc_exp, acc_act;

  always #5 clk = ~clk;

  mem_intf_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_val(m0_val), .m0_accept(m0_accept), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wen(m0_wen), .m0_ren(m0_ren), .m0_rdata(m0_rdata), .m0_error(m0_error),
    .m1_val(m1_val), .m1_accept(m1_accept), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wen(m1_wen), .m1_ren(m1_ren), .m1_rdata(m1_rdata), .m1_error(m1_error),
    .s_val(s_val), .s_accept(s_accept), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wen(s_wen), .s_ren(s_ren), .s_rdata(s_rdata), .s_error(s_error),
    .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Completion monitor.
  always @(negedge clk) begin
    if (m0_accept || m1_accept) begin
      check("one_accept", m0_accept && m1_accept, 0);
      check("acc_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        acc_exp = exp_q.pop_front();
        acc_act = m1_accept ? {1'b1, m1_rdata, m1_error} : {1'b0, m0_rdata, m0_error};
        check("accept_resp", acc_act, acc_exp);
        check("other_port_quiet", m1_accept ? {m0_rdata, m0_error} : {m1_rdata, m1_error}, 0);
      end
    end
  end

  // Downstream monitor: each new s_val pops one request, which must then hold.
  always @(negedge clk) begin
    if (s_val) begin
      if (!s_active) begin
        check("s_req_expected", s_exp_q.size() != 0, 1);
        if (s_exp_q.size() != 0) s_cur_exp = s_exp_q.pop_front();
      end
      check("s_req", {s_addr, s_wdata, s_wen, s_ren}, s_cur_exp);
    end
    s_active = s_val && !s_accept;
  end

  task automatic drive(input logic p, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] we, input logic re);
    if (p) begin
      m1_addr = a; m1_wdata = wd; m1_wen = we; m1_ren = re; m1_val = 1'b1;
    end else begin
      m0_addr = a; m0_wdata = wd; m0_wen = we; m0_ren = re; m0_val = 1'b1;
    end
  endtask

  // Slave model: accepts in the (stall+1)-th cycle after s_val first seen.
  task automatic serve(input int stall, input logic [31:0] rd, input logic [31:0] er);
    int n = 0;
    @(negedge clk);
    while (!s_val && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_latency", n, 1);
    if (!s_val) return;
    repeat (stall + 1) @(posedge clk);
    #1; s_accept = 1'b1; s_rdata = rd; s_error = er;
    @(posedge clk);
    #1; s_accept = 1'b0; s_rdata = 32'h0; s_error = 32'h0;
    @(negedge clk);
    check("gap_s_val", s_val, 0);
    check("gap_busy", busy, 1);
  endtask

  // One requester transaction; entered and left at posedge+1 of an IDLE cycle.
  task automatic xact(input logic p, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] we, input logic re, input int stall,
                      input logic [31:0] rd, input logic [31:0] er);
    logic nul;
    nul = (we == 4'h0) && !re;
    drive(p, a, wd, we, re);
    exp_q.push_back({p, nul ? 32'h0 : rd, nul ? 32'h0 : er});
    if (nul) begin
      @(negedge clk);
      check("null_early", p ? m1_accept : m0_accept, 0);
      @(posedge clk); #1;
      s_rdata = rd; s_error = er;
      @(negedge clk);
      check("null_accept", p ? m1_accept : m0_accept, 1);
      check("null_s_val", s_val, 0);
      @(posedge clk); #1;
      s_rdata = 32'h0; s_error = 32'h0;
      @(negedge clk);
      check("null_gap_s_val", s_val, 0);
    end else begin
      s_exp_q.push_back({a, wd, we, re && (we == 4'h0)});
      serve(stall, rd, er);
    end
    if (p) m1_val = 1'b0; else m0_val = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    m0_val = 0; m0_addr = 0; m0_wdata = 0; m0_wen = 0; m0_ren = 0;
    m1_val = 0; m1_addr = 0; m1_wdata = 0; m1_wen = 0; m1_ren = 0;
    s_accept = 0; s_rdata = 0; s_error = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_val", s_val, 0);
    check("rst_busy", busy, 0);
    check("rst_accepts", {m0_accept, m1_accept}, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_s_fields", {s_addr, s_wdata, s_wen, s_ren}, 0);
    check("rst_state", state_dbg, IDLE);
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention from reset: 0,1,0,1 under sustained requests.
    drive(1'b0, 32'h200, 32'h0, 4'h0, 1'b1);
    drive(1'b1, 32'h300, 32'hCAFE0001, 4'hF, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        s_exp_q.push_back({32'h200, 32'h0, 4'h0, 1'b1});
        exp_q.push_back({1'b0, 32'hA0 + 32'(k), 32'h0});
      end else begin
        s_exp_q.push_back({32'h300, 32'hCAFE0001, 4'hF, 1'b0});
        exp_q.push_back({1'b1, 32'hA0 + 32'(k), 32'h0});
      end
    end
    for (int k = 0; k < 4; k++) serve(1, 32'hA0 + 32'(k), 32'h0);
    m0_val = 1'b0; m1_val = 1'b0;
    @(posedge clk); #1;

    xact(1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 2, 32'hDEADBEEF, 32'h0);
    xact(1'b1, 32'h40, 32'h12345678, 4'b0011, 1'b1, 5, 32'h0, 32'h5);
    xact(1'b0, 32'hFFFFFFFC, 32'hA5A5A5A5, 4'hF, 1'b0, 0, 32'h0, 32'h0);
    xact(1'b0, 32'h80, 32'hFFFF, 4'h0, 1'b0, 0, 32'h1234, 32'h1);
    check("no_timeout_yet", timeout_err, 0);

    // Watchdog: no accept for 10 GRANT cycles.
    drive(1'b1, 32'h500, 32'h0, 4'h0, 1'b1);
    s_exp_q.push_back({32'h500, 32'h0, 4'h0, 1'b1});
    exp_q.push_back({1'b1, 32'h77, 32'h0});
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("wd_err", timeout_err, (i >= TO));
      check("wd_state", state_dbg, GRANT);
      @(posedge clk); #1;
    end
    s_accept = 1'b1; s_rdata = 32'h77;
    @(negedge clk);
    check("wd_err_at_accept", timeout_err, 1);
    @(posedge clk); #1;
    s_accept = 1'b0; s_rdata = 32'h0; m1_val = 1'b0;
    @(negedge clk);
    check("wd_gap_s_val", s_val, 0);
    @(posedge clk); #1;
    xact(1'b0, 32'h600, 32'h0, 4'h0, 1'b1, 0, 32'h66, 32'h0);
    check("wd_sticky", timeout_err, 1);

    // Reset while GRANT is waiting on the slave.
    drive(1'b0, 32'h700, 32'h0, 4'h0, 1'b1);
    s_exp_q.push_back({32'h700, 32'h0, 4'h0, 1'b1});
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_s_val", s_val, 1);
    @(posedge clk); #1;
    rst = 1'b1; m0_val = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_s_val", s_val, 0);
    check("midrst_busy", busy, 0);
    check("midrst_accepts", {m0_accept, m1_accept}, 0);
    check("midrst_timeout", timeout_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    drive(1'b0, 32'h800, 32'h0, 4'h0, 1'b1);
    drive(1'b1, 32'h900, 32'h0, 4'h0, 1'b1);
    s_exp_q.push_back({32'h800, 32'h0, 4'h0, 1'b1});
    s_exp_q.push_back({32'h900, 32'h0, 4'h0, 1'b1});
    exp_q.push_back({1'b0, 32'h88, 32'h0});
    exp_q.push_back({1'b1, 32'h99, 32'h0});
    serve(0, 32'h88, 32'h0);
    serve(0, 32'h99, 32'h0);
    m0_val = 1'b0; m1_val = 1'b0;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("acc_queue_drained", exp_q.size(), 0);
    check("s_queue_drained", s_exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
